// File: rtl/arranque_rampa_param.sv
`default_nettype none
// arranque_rampa_param: staged soft-start ramp controller (IDLE/RAMP_UP/RUN/RAMP_DOWN).
// Optional macro RAMPDOWN_EN: Parar ramps stages down instead of dropping them at once.
module arranque_rampa_param #(
  parameter int N_STEPS    = 3,
  parameter int CLK_DIV    = 100000000,
  parameter int DWELL_FAST = 1,
  parameter int DWELL_SLOW = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Rapido,
  input  logic                         Lento,
  input  logic                         Parar,
  output logic [N_STEPS-1:0]           level,
  output logic [$clog2(N_STEPS+1)-1:0] step_idx,
  output logic                         busy,
  output logic                         running
);

  localparam int SW     = $clog2(N_STEPS + 1);
  localparam int PW     = $clog2(CLK_DIV + 1);
  localparam int DMAX   = (DWELL_FAST > DWELL_SLOW) ? DWELL_FAST : DWELL_SLOW;
  localparam int DW     = $clog2(DMAX + 1);
  localparam logic [SW-1:0] LAST    = SW'(N_STEPS);
  localparam logic [SW-1:0] ONE     = SW'(1);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DF_MAX  = DW'(DWELL_FAST - 1);
  localparam logic [DW-1:0] DS_MAX  = DW'(DWELL_SLOW - 1);

`ifdef RAMPDOWN_EN
  typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;
`else
  typedef enum logic [1:0] {IDLE, RAMP_UP, RUN} state_t;
`endif

  state_t        state, state_nx;
  logic [SW-1:0] step_nx;
  logic [PW-1:0] pre, pre_nx;
  logic [DW-1:0] dw, dw_nx, dw_max;
  logic          mode_fast, mode_nx;
  logic          tick, stop_req, changed, ramping, ramping_nx;
  logic [N_STEPS-1:0] level_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      step_idx  <= '0;
      pre       <= '0;
      dw        <= '0;
      mode_fast <= 1'b0;
      level     <= '0;
      busy      <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_nx;
      step_idx  <= step_nx;
      pre       <= pre_nx;
      dw        <= dw_nx;
      mode_fast <= mode_nx;
      level     <= level_nx;
      busy      <= ramping_nx;
      running   <= (state_nx == RUN);
    end
  end

  always_comb begin
    state_nx = state;
    step_nx  = step_idx;
    mode_nx  = mode_fast;
    dw_nx    = dw;
    tick     = (pre == PRE_MAX);
    dw_max   = mode_fast ? DF_MAX : DS_MAX;
    stop_req = Parar && (state == RAMP_UP || state == RUN);
`ifdef RAMPDOWN_EN
    ramping    = (state == RAMP_UP) || (state == RAMP_DOWN);
    ramping_nx = (state_nx == RAMP_UP) || (state_nx == RAMP_DOWN);
`else
    ramping    = (state == RAMP_UP);
    ramping_nx = (state_nx == RAMP_UP);
`endif

    if (stop_req) begin
`ifdef RAMPDOWN_EN
      state_nx = RAMP_DOWN;
`else
      state_nx = IDLE;
      step_nx  = '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if ((Rapido || Lento) && !Parar) begin
            step_nx  = ONE;
            mode_nx  = Rapido;
            state_nx = (ONE == LAST) ? RUN : RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (tick) begin
            if (dw == dw_max) begin
              step_nx = step_idx + ONE;
              if (step_nx == LAST) state_nx = RUN;
            end else begin
              dw_nx = dw + DW'(1);
            end
          end
        end
        RUN: ;
`ifdef RAMPDOWN_EN
        RAMP_DOWN: begin
          if (tick) begin
            if (dw == dw_max) begin
              step_nx = step_idx - ONE;
              if (step_nx == '0) state_nx = IDLE;
            end else begin
              dw_nx = dw + DW'(1);
            end
          end
        end
`endif
        default: state_nx = IDLE;
      endcase
    end

`ifdef RAMPDOWN_EN
    ramping_nx = (state_nx == RAMP_UP) || (state_nx == RAMP_DOWN);
`else
    ramping_nx = (state_nx == RAMP_UP);
`endif

    // Every state entry or step change restarts the dwell timing from zero.
    changed = (state_nx != state) || (step_nx != step_idx);
    if (changed) begin
      pre_nx = '0;
      dw_nx  = '0;
    end else if (ramping) begin
      pre_nx = tick ? '0 : pre + PW'(1);
    end else begin
      pre_nx = '0;
    end

    level_nx = '0;
    for (int k = 0; k < N_STEPS; k++) level_nx[k] = (k < int'(step_nx));
  end

endmodule
`default_nettype wire

// File: tb/tb_arranque_rampa_param.sv
`default_nettype none
// tb_arranque_rampa_param: directed vector table plus reset corner sequences.
module tb_arranque_rampa_param;

  logic       clk = 1'b0;
  logic       reset, Rapido, Lento, Parar;
  logic [2:0] level;
  logic [1:0] step_idx;
  logic       busy, running;

  int checks = 0;
  int errors = 0;

  arranque_rampa_param #(
    .N_STEPS(3), .CLK_DIV(4), .DWELL_FAST(1), .DWELL_SLOW(3)
  ) dut (
    .clk(clk), .reset(reset), .Rapido(Rapido), .Lento(Lento), .Parar(Parar),
    .level(level), .step_idx(step_idx), .busy(busy), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         scen;
    int         cyc;
    logic [2:0] level;
    logic [1:0] step;
    logic       busy;
    logic       running;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int s, input int c, input logic [2:0] l,
                     input logic [1:0] st, input logic b, input logic r);
    vec_t v;
    v.scen = s; v.cyc = c; v.level = l; v.step = st; v.busy = b; v.running = r;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] l, input logic [1:0] st,
                         input logic b, input logic r);
    chk({tag, " level"},   32'(level),    32'(l));
    chk({tag, " step"},    32'(step_idx), 32'(st));
    chk({tag, " busy"},    32'(busy),     32'(b));
    chk({tag, " running"}, 32'(running),  32'(r));
  endtask

  // Scenarios: 0 fast, 1 slow, 2 both starts, 3 stop from RUN, 4 Parar blocks start, 5 stop mid-ramp
  task automatic drive(input int s, input int c);
    Rapido = 1'b0; Lento = 1'b0; Parar = 1'b0;
    case (s)
      0: Rapido = (c == 0);
      1: Lento  = (c == 0);
      2: begin Rapido = (c == 0); Lento = (c == 0); end
      3: begin Rapido = (c == 0); Parar = (c == 20); end
      4: begin Rapido = (c <= 10); Parar = (c <= 5); end
      5: begin Rapido = (c == 0); Parar = (c == 6); end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    Rapido = 1'b0; Lento = 1'b0; Parar = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; Rapido = 1'b0; Lento = 1'b0; Parar = 1'b0;

    add(0, 0, 3'b000, 2'd0, 0, 0);
    add(0, 1, 3'b001, 2'd1, 1, 0);
    add(0, 4, 3'b001, 2'd1, 1, 0);
    add(0, 5, 3'b011, 2'd2, 1, 0);
    add(0, 8, 3'b011, 2'd2, 1, 0);
    add(0, 9, 3'b111, 2'd3, 0, 1);
    add(0, 15, 3'b111, 2'd3, 0, 1);
    add(1, 1, 3'b001, 2'd1, 1, 0);
    add(1, 12, 3'b001, 2'd1, 1, 0);
    add(1, 13, 3'b011, 2'd2, 1, 0);
    add(1, 24, 3'b011, 2'd2, 1, 0);
    add(1, 25, 3'b111, 2'd3, 0, 1);
    add(2, 4, 3'b001, 2'd1, 1, 0);
    add(2, 5, 3'b011, 2'd2, 1, 0);
    add(2, 9, 3'b111, 2'd3, 0, 1);
    add(3, 20, 3'b111, 2'd3, 0, 1);
`ifdef RAMPDOWN_EN
    add(3, 21, 3'b111, 2'd3, 1, 0);
    add(3, 24, 3'b111, 2'd3, 1, 0);
    add(3, 25, 3'b011, 2'd2, 1, 0);
    add(3, 29, 3'b001, 2'd1, 1, 0);
    add(3, 32, 3'b001, 2'd1, 1, 0);
    add(3, 33, 3'b000, 2'd0, 0, 0);
    add(3, 36, 3'b000, 2'd0, 0, 0);
    add(5, 7, 3'b011, 2'd2, 1, 0);
    add(5, 10, 3'b011, 2'd2, 1, 0);
    add(5, 11, 3'b001, 2'd1, 1, 0);
    add(5, 14, 3'b001, 2'd1, 1, 0);
    add(5, 15, 3'b000, 2'd0, 0, 0);
`else
    add(3, 21, 3'b000, 2'd0, 0, 0);
    add(3, 25, 3'b000, 2'd0, 0, 0);
    add(5, 7, 3'b000, 2'd0, 0, 0);
    add(5, 12, 3'b000, 2'd0, 0, 0);
`endif
    add(4, 1, 3'b000, 2'd0, 0, 0);
    add(4, 6, 3'b000, 2'd0, 0, 0);
    add(4, 7, 3'b001, 2'd1, 1, 0);

    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int c = 0; c <= 40; c++) begin
        foreach (vecs[i])
          if (vecs[i].scen == s && vecs[i].cyc == c)
            chk_all($sformatf("s%0d c%0d", s, c), vecs[i].level, vecs[i].step,
                    vecs[i].busy, vecs[i].running);
        drive(s, c);
        @(posedge clk);
        #1;
      end
    end

    // Reset mid-ramp drops outputs without an edge; a held start restarts at once.
    do_reset();
    Rapido = 1'b1;
    @(posedge clk); #1 Rapido = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk_all("pre-reset c6", 3'b011, 2'd2, 1, 0);
    reset = 1'b1;
    #1 chk_all("async reset", 3'b000, 2'd0, 0, 0);
    Rapido = 1'b1;
    @(posedge clk);
    #1 chk_all("in reset", 3'b000, 2'd0, 0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1 chk_all("restart", 3'b001, 2'd1, 1, 0);
    Rapido = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arranque_rampa_param.md
ARRANQUE_RAMPA_PARAM -- requirements
Module: arranque_rampa_param

Interface
REQ-001 The block SHALL expose parameter N_STEPS, default 3, number of ramp levels (valid range 1..16).
REQ-002 The block SHALL expose parameter CLK_DIV, default 100000000, clk cycles per time tick (valid range 1 and up).
REQ-003 The block SHALL expose parameter DWELL_FAST, default 1, ticks held per step in fast mode (valid range 1 and up).
REQ-004 The block SHALL expose parameter DWELL_SLOW, default 3, ticks held per step in slow mode (valid range 1 and up).
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 Port clk, input, 1: system clock, rising edge.
REQ-007 Port reset, input, 1: asynchronous active-high reset.
REQ-008 Port Rapido, input, 1: start request, fast mode.
REQ-009 Port Lento, input, 1: start request, slow mode.
REQ-010 Port Parar, input, 1: stop request.
REQ-011 Port level, output, N_STEPS: thermometer-coded ramp level; bit k drives stage k.
REQ-012 Port step_idx, output, clog2(N_STEPS+1): number of active stages.
REQ-013 Port busy, output, 1: ramping up or down.
REQ-014 Port running, output, 1: all stages on, steady state.

Function
REQ-015 FSM states SHALL be IDLE, RAMP_UP, RUN and RAMP_DOWN.
REQ-016 The internal prescaler SHALL count 0..CLK_DIV-1, emit a 1-cycle tick at CLK_DIV-1, and clear on every state entry and on every step change.
REQ-017 IDLE SHALL go to RAMP_UP when (Rapido or Lento) and not Parar, set step_idx=1 on the next edge, and latch the mode.
REQ-018 Latched mode SHALL be fast if Rapido=1, including Rapido=Lento=1, and slow otherwise; mode is frozen until IDLE.
REQ-019 RAMP_UP SHALL increment step_idx after DWELL ticks for the latched mode; reaching N_STEPS SHALL move to RUN in the same edge.
REQ-020 RUN SHALL hold step_idx=N_STEPS; Rapido and Lento are ignored.
REQ-021 Parar in RAMP_UP or RUN SHALL take effect on the next edge per REQ-031/REQ-032, starting from the current step_idx.
REQ-022 RAMP_DOWN SHALL decrement step_idx after DWELL ticks of the latched mode; reaching 0 SHALL move to IDLE.
REQ-023 Start inputs SHALL be ignored in RAMP_DOWN; Parar held in IDLE SHALL block any start.
REQ-024 Outputs SHALL be registered: level[k]=(k<step_idx), busy=state in {RAMP_UP, RAMP_DOWN}, running=state is RUN.
REQ-025 With N_STEPS=1, the first RAMP_UP step SHALL go directly to RUN at step_idx=1.

Reset
REQ-026 Reset SHALL asynchronously force IDLE, step_idx=0, level=0, busy=0, running=0, and clear the prescaler and dwell counters.
REQ-027 Reset asserted mid-ramp SHALL drop all outputs immediately, with no ramp-down.
REQ-028 After reset deasserts, a start input still high SHALL start a new ramp on the first active edge.

Configuration
REQ-029 Macro RAMPDOWN_EN SHALL select the stop behaviour.
REQ-030 The macro SHALL be either defined or undefined; no other mechanism changes this behaviour.
REQ-031 With RAMPDOWN_EN defined, Parar SHALL enter RAMP_DOWN (REQ-022).
REQ-032 With RAMPDOWN_EN undefined, the RAMP_DOWN state SHALL not exist, and Parar SHALL force IDLE with level=0 on the next edge.

Verification (N_STEPS=3, CLK_DIV=4, DWELL_FAST=1, DWELL_SLOW=3)
REQ-033 Fast ramp: Rapido=1 at cycle 0 -> level=001 at cycle 1, 011 at cycle 5, 111 at cycle 9, running=1 at cycle 9, busy=1 at cycles 1-8.
REQ-034 Slow ramp: Lento=1 at cycle 0 -> level=001 at cycle 1, 011 at cycle 13, 111 at cycle 25.
REQ-035 Ramp-down with RAMPDOWN_EN: fast RUN, then Parar at cycle 20 -> level=011 at cycle 25, 001 at cycle 29, 000 at cycle 33, IDLE.
REQ-036 Stop without RAMPDOWN_EN: same stimulus as REQ-035 -> level=000 and IDLE at cycle 21.
REQ-037 Reset mid-ramp: reset at cycle 6 during fast ramp -> level=000 and busy=0 without waiting for a clock edge.
REQ-038 Priority: Rapido=Lento=1 -> fast timing as in REQ-033; Parar=1 with Rapido=1 in IDLE -> stays IDLE, level=000.
